// File: rtl/uart_rx_ctrl_if.sv
// ============================================================================
// Module   : uart_rx_ctrl_if
// Purpose  : Serial-side inputs and byte-side outputs of the UART receive
//            controller, grouped so that producer and consumer share one bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 sample_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;
  logic [2:0]           state;

  // master: tick generator / line side plus byte consumer
  modport master (
    output sample_tick, rx,
    input  data, data_valid, frame_err, parity_err, busy, state
  );

  // slave: the receive controller itself
  modport slave (
    input  sample_tick, rx,
    output data, data_valid, frame_err, parity_err, busy, state
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : Oversampling UART receiver with start-bit glitch rejection,
//            framing error and optional parity check (macro UART_RX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_ctrl_if.slave   bus
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_start  = 3'd1;
  localparam logic [2:0] c_data   = 3'd2;
  localparam logic [2:0] c_parity = 3'd3;
  localparam logic [2:0] c_stop   = 3'd4;

  localparam logic [OSW-1:0] c_os_half = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] c_os_last = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] c_bit_last = BCW'(DATA_BITS - 1);

  logic [2:0]           state_q,      state_d;
  logic [OSW-1:0]       os_cnt_q,     os_cnt_d;
  logic [BCW-1:0]       bit_cnt_q,    bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,      shift_d;
  logic [DATA_BITS-1:0] data_q,       data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q,  frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 mismatch_q,   mismatch_d;

  logic os_wrap;
  logic [OSW-1:0] os_next;

  // Mid-bit sample point in DATA/PARITY/STOP; counter wraps explicitly so
  // non-power-of-two oversample ratios keep the right bit period.
  assign os_wrap = (os_cnt_q == c_os_last);
  assign os_next = os_wrap ? '0 : os_cnt_q + 1'b1;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= c_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    if (bus.sample_tick) begin
      case (state_q)
        c_idle:   if (!bus.rx) state_d = c_start;
        c_start:  if (os_cnt_q == c_os_half) state_d = bus.rx ? c_idle : c_data;
        c_data: begin
          if (os_wrap && (bit_cnt_q == c_bit_last)) begin
`ifdef UART_RX_PARITY_EN
            state_d = c_parity;
`else
            state_d = c_stop;
`endif
          end
        end
        c_parity: begin
          if (os_wrap) begin
`ifdef UART_RX_PARITY_EN
            state_d = c_stop;
`else
            state_d = c_idle;
`endif
          end
        end
        c_stop:   if (os_wrap) state_d = c_idle;
        default:  state_d = c_idle;
      endcase
    end
  end

  // ----------------------------------------------------- datapath and outputs
  always_comb begin
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    mismatch_d   = mismatch_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    if (bus.sample_tick) begin
      case (state_q)
        c_idle: begin
          os_cnt_d  = '0;
          bit_cnt_d = '0;
        end
        c_start: begin
          if (os_cnt_q == c_os_half) begin
            os_cnt_d  = '0;
            bit_cnt_d = '0;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
        c_data: begin
          os_cnt_d = os_next;
          if (os_wrap) begin
            shift_d   = {bus.rx, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        c_parity: begin
          os_cnt_d = os_next;
`ifdef UART_RX_PARITY_EN
          if (os_wrap) mismatch_d = (^shift_q) ^ bus.rx ^ 1'(PARITY_ODD);
`endif
        end
        c_stop: begin
          os_cnt_d = os_next;
          if (os_wrap) begin
            data_d       = shift_q;
            data_valid_d = bus.rx;
            frame_err_d  = !bus.rx;
`ifdef UART_RX_PARITY_EN
            parity_err_d = bus.rx & mismatch_q;
`endif
          end
        end
        default: begin
          os_cnt_d  = '0;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      mismatch_q   <= 1'b0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      mismatch_q   <= mismatch_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

`ifndef UART_RX_PARITY_EN
  // Parity sense and stored mismatch have no consumer without the parity stage.
  logic unused_parity;
  assign unused_parity = 1'(PARITY_ODD) ^ mismatch_q ^ parity_err_q;
`endif

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign bus.busy       = (state_q != c_idle);
  assign bus.state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Directed self-checking bench for uart_rx_ctrl (8 data bits,
//            16x oversample, one sample_tick every 4th clk).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int OS          = 16;
  localparam int STOP_T      = OS / 2 + (8 + P + 1) * OS;
  localparam int FRAME_TICKS = (8 + P + 2) * OS;

  logic clk = 1'b0;
  logic reset;

  uart_rx_ctrl_if #(.DATA_BITS(8)) bus ();

  uart_rx_ctrl #(
    .DATA_BITS (8),
    .OVERSAMPLE(OS),
    .PARITY_ODD(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int         tick_no = 0;
  int         dv_ticks[$];
  logic [7:0] dv_data[$];
  int         fe_ticks[$];
  int         pe_ticks[$];
  logic [2:0] last_state;
  logic       last_busy;

  int dv_cycles = 0;
  int fe_cycles = 0;
  int pe_cycles = 0;
  int both_cycles = 0;

  // Pulse-width and exclusivity monitor
  always @(negedge clk) begin
    if (bus.data_valid) dv_cycles++;
    if (bus.frame_err) fe_cycles++;
    if (bus.parity_err) pe_cycles++;
    if (bus.data_valid && bus.frame_err) both_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    dv_ticks.delete();
    dv_data.delete();
    fe_ticks.delete();
    pe_ticks.delete();
    dv_cycles = 0;
    fe_cycles = 0;
    pe_cycles = 0;
  endtask

  // One oversample tick: strobe high across exactly one posedge, then 3 idle clks
  task automatic do_tick();
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    last_state = bus.state;
    last_busy  = bus.busy;
    if (bus.data_valid) begin
      dv_ticks.push_back(tick_no);
      dv_data.push_back(bus.data);
    end
    if (bus.frame_err) fe_ticks.push_back(tick_no);
    if (bus.parity_err) pe_ticks.push_back(tick_no);
    tick_no++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int n);
    bus.rx = b;
    for (int k = 0; k < n; k++) do_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input int stop_ticks);
    send_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) send_bit(d[i], OS);
    if (P == 1) send_bit(par, OS);
    send_bit(stop, stop_ticks);
  endtask

  int t0;
  int t_a;
  int t_b;

  initial begin
    reset           = 1'b0;
    bus.sample_tick = 1'b0;
    bus.rx          = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_data", 32'(bus.data), 32'h00);
    check("reset_dv", 32'(bus.data_valid), 32'd0);
    check("reset_fe", 32'(bus.frame_err), 32'd0);
    check("reset_pe", 32'(bus.parity_err), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    send_bit(1'b1, 3);

    // Clean frame 0xA5
    clear_obs();
    t0 = tick_no;
    send_frame(8'hA5, 1'b1, ^8'hA5, OS);
    check("a5_dv_count", 32'(dv_ticks.size()), 32'd1);
    t_a = (dv_ticks.size() > 0) ? dv_ticks[0] - t0 : -1;
    check("a5_dv_tick", 32'(t_a), 32'(STOP_T));
    check("a5_data", (dv_data.size() > 0) ? 32'(dv_data[0]) : 32'hFFFF_FFFF, 32'hA5);
    check("a5_fe_count", 32'(fe_ticks.size()), 32'd0);
    check("a5_dv_width", 32'(dv_cycles), 32'd1);
    check("a5_busy_after", 32'(last_busy), 32'd0);

    // Start-bit glitch: 4 low ticks then high, reject at tick 8
    clear_obs();
    send_bit(1'b0, 4);
    check("glitch_busy", 32'(last_busy), 32'd1);
    send_bit(1'b1, 4);
    check("glitch_state_t7", 32'(last_state), 32'd1);
    send_bit(1'b1, 1);
    check("glitch_state_t8", 32'(last_state), 32'd0);
    send_bit(1'b1, 16);
    check("glitch_no_dv", 32'(dv_cycles), 32'd0);
    check("glitch_no_fe", 32'(fe_cycles), 32'd0);
    check("glitch_data_held", 32'(bus.data), 32'hA5);

    // Framing error 0x3C: stop bit low, cut off right after the stop sample
    clear_obs();
    t0 = tick_no;
    send_frame(8'h3C, 1'b0, ^8'h3C, OS / 2 + 1);
    check("fe_count", 32'(fe_ticks.size()), 32'd1);
    t_a = (fe_ticks.size() > 0) ? fe_ticks[0] - t0 : -1;
    check("fe_tick", 32'(t_a), 32'(STOP_T));
    check("fe_width", 32'(fe_cycles), 32'd1);
    check("fe_no_dv", 32'(dv_cycles), 32'd0);
    check("fe_data", 32'(bus.data), 32'h3C);
    check("fe_state_idle", 32'(last_state), 32'd0);
    send_bit(1'b0, 1);
    check("fe_restart", 32'(last_state), 32'd1);
    send_bit(1'b1, 24);
    check("fe_drain_idle", 32'(last_state), 32'd0);
    check("fe_drain_no_dv", 32'(dv_cycles), 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, parity bit 0 is wrong, 1 is right
    clear_obs();
    t0 = tick_no;
    send_frame(8'h07, 1'b1, 1'b0, OS);
    t_a = (dv_ticks.size() > 0) ? dv_ticks[0] - t0 : -1;
    check("par_bad_dv_tick", 32'(t_a), 32'(STOP_T));
    check("par_bad_pe_count", 32'(pe_ticks.size()), 32'd1);
    t_b = (pe_ticks.size() > 0) ? pe_ticks[0] - t0 : -2;
    check("par_bad_pe_tick", 32'(t_b), 32'(t_a));
    check("par_bad_pe_width", 32'(pe_cycles), 32'd1);
    clear_obs();
    send_frame(8'h07, 1'b1, 1'b1, OS);
    check("par_ok_dv_count", 32'(dv_ticks.size()), 32'd1);
    check("par_ok_pe_count", 32'(pe_cycles), 32'd0);
`endif

    // Reset in the middle of data bit 3, then a clean 0x5A
    clear_obs();
    send_bit(1'b0, OS);
    send_bit(1'b1, OS);
    send_bit(1'b1, OS);
    send_bit(1'b0, OS);
    send_bit(1'b0, OS / 2);
    check("mid_state_data", 32'(last_state), 32'd2);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 32'(bus.state), 32'd0);
    check("mid_rst_data", 32'(bus.data), 32'h00);
    check("mid_rst_dv", 32'(bus.data_valid), 32'd0);
    check("mid_rst_fe", 32'(bus.frame_err), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    send_bit(1'b1, 20);
    check("mid_no_pulse", 32'(dv_cycles + fe_cycles), 32'd0);
    clear_obs();
    send_frame(8'h5A, 1'b1, ^8'h5A, OS);
    check("post_rst_dv_count", 32'(dv_ticks.size()), 32'd1);
    check("post_rst_data", (dv_data.size() > 0) ? 32'(dv_data[0]) : 32'hFFFF_FFFF, 32'h5A);
    check("post_rst_fe", 32'(fe_cycles), 32'd0);

    // Back-to-back 0xFF then 0x00, no idle between frames
    clear_obs();
    send_frame(8'hFF, 1'b1, ^8'hFF, OS);
    send_frame(8'h00, 1'b1, ^8'h00, OS);
    send_bit(1'b1, 4);
    check("b2b_dv_count", 32'(dv_ticks.size()), 32'd2);
    check("b2b_dv_width", 32'(dv_cycles), 32'd2);
    check("b2b_data0", (dv_data.size() > 0) ? 32'(dv_data[0]) : 32'hFFFF_FFFF, 32'hFF);
    check("b2b_data1", (dv_data.size() > 1) ? 32'(dv_data[1]) : 32'hFFFF_FFFF, 32'h00);
    t_a = (dv_ticks.size() > 1) ? dv_ticks[1] - dv_ticks[0] : -1;
    check("b2b_spacing", 32'(t_a), 32'(FRAME_TICKS));

    check("dv_fe_exclusive", 32'(both_cycles), 32'd0);
`ifndef UART_RX_PARITY_EN
    check("pe_tied_low", 32'(pe_cycles), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Parametrised UART receive controller. It is the next generation of the two-state receive controller: it owns its own oversample and bit counters, the data shift register, start-bit glitch rejection and error detection. It sits between the rx input synchroniser and the byte consumer, and is driven by an external oversampling tick generator.

## Interface
- DATA_BITS, 8, data bits per frame (5..9), LSB first
- OVERSAMPLE, 16, sample_tick strobes per bit period (even, >= 4)
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd
- clk  input  1  clock, all logic on posedge
- reset  input  1  synchronous, active-low; has priority over all other logic
- sample_tick  input  1  single-cycle strobe at baud x OVERSAMPLE
- rx  input  1  serial line, already synchronised to clk, idle high
- data  output  DATA_BITS  last received word; held until the next frame completes
- data_valid  output  1  one-cycle pulse: the frame's stop bit was good
- frame_err  output  1  one-cycle pulse: the stop bit was sampled low
- parity_err  output  1  one-cycle pulse, coincident with data_valid, on parity mismatch
- busy  output  1  high in every state except IDLE
- state  output  3  current state encoding, for debug

## Operation
- States: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- All state changes occur only on clk edges where sample_tick=1. While sample_tick=0, all state is held and rx is ignored.
- IDLE: a tick with rx=0 is the detection tick. Go to START and clear os_cnt.
- START: os_cnt increments per tick. On the tick where os_cnt = OVERSAMPLE/2-1 (OVERSAMPLE/2 ticks after detection), sample rx:
  - rx=1: glitch; return to IDLE with no output activity.
  - rx=0: go to DATA, clear os_cnt and bit_cnt.
- DATA: on every OVERSAMPLE-th tick (os_cnt = OVERSAMPLE-1, then os_cnt wraps to 0), sample rx and shift it into shift-register bit DATA_BITS-1, shifting right. bit_cnt increments. After the DATA_BITS-th sample, go to PARITY if UART_RX_PARITY_EN is defined, otherwise to STOP.
- PARITY: sample at the same point. Store mismatch = (^shift ^ sample ^ PARITY_ODD); go to STOP.
- STOP: sample at the same point, then update data from the shift register and return to IDLE on the same edge.
  - rx=1: pulse data_valid, and pulse parity_err if the stored mismatch is set.
  - rx=0: pulse frame_err only; data is still updated, data_valid and parity_err stay 0.
- Returning to IDLE at mid-stop lets a following start bit be detected on the very next tick.
- A stop bit sampled low leaves rx low. IDLE therefore re-enters START on the next tick. This is the required behaviour (break appears as repeated frame_err).
- Counter widths: os_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS+1) bits.

## Timing
- Reset (reset=0 at a clk edge) has these effects on that edge:
  - state=IDLE, data=0, and data_valid, frame_err, parity_err and busy all 0.
  - All counters, the shift register and the stored mismatch are cleared.
- Reset mid-frame abandons the frame with no pulse.
- With the detection tick as tick 0 (P = 1 if parity compiled in, else 0):
  - Start bit sampled at tick OVERSAMPLE/2.
  - Data bit i sampled at tick OVERSAMPLE/2 + (i+1)*OVERSAMPLE.
  - Stop bit sampled at tick OVERSAMPLE/2 + (DATA_BITS+P+1)*OVERSAMPLE.
- Outputs are registered. data, data_valid, frame_err and parity_err change on the clk edge of the stop-sample tick. Pulses last exactly one clk cycle, even when sample_tick is high on consecutive cycles.
- busy rises on the detection-tick edge and falls on the stop-sample or glitch-reject edge.
- data_valid and frame_err are never high together.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state and a parity bit between the data and stop bits are included; parity_err is live.
- UART_RX_PARITY_EN undefined: PARITY is unreachable, DATA goes straight to STOP, and parity_err is tied to 0. The port list is unchanged.

## Test plan
- 8N1, OVERSAMPLE=16, sample_tick every 4th clk, send 0xA5 -> data=0xA5; data_valid high one cycle on tick 152 after detection; frame_err=0; busy low afterwards.
- rx low for 4 ticks, then high -> START aborts at tick 8, back to IDLE; no data_valid or frame_err; data unchanged.
- Send 0x3C with the stop bit driven 0 -> frame_err one-cycle pulse at tick 152; data_valid=0; data=0x3C; next tick re-enters START.
- UART_RX_PARITY_EN, PARITY_ODD=0, send 0x07 with parity bit 0 -> data_valid and parity_err pulse together at tick 168; with parity bit 1 -> parity_err=0.
- Assert reset for one edge mid-DATA (bit 3) -> on that edge all outputs 0 and state=0; a following 0x5A frame is received correctly.
- Two back-to-back frames 0xFF then 0x00 with no idle gap -> two data_valid pulses, carrying 0xFF then 0x00, 160 ticks apart.
